// File: rtl/bcd_to_unsigned_pkg.sv
// Shared BCD constants, FSM state type and helpers for the BCD
// converter pair (bcd_to_unsigned and unsigned_to_bcd).
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int DIGIT_MAX   = 9;

    // Forward double dabble adds 3 at >=5; reverse subtracts 3 at >=8.
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] SUB3_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] CORR_VAL    = 4'd3;

    function automatic logic digit_valid(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return d <= DIGIT_MAX[BCD_DIGIT_W-1:0];
    endfunction

    // Smallest W with 2^W >= 10^n, i.e. 2^W > 10^n - 1.
    function automatic int bin_width_for(input int n);
        logic [255:0] v;
        int           w;
        v = 256'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 256'd10;
        end
        w = 0;
        while ((256'd1 << w) < v) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Per-digit reverse double dabble correction: subtract 3 when >= 8.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_d,
    output logic [BCD_DIGIT_W-1:0] o_d
);

    assign o_d = (i_d >= SUB3_THRESH) ? (i_d - CORR_VAL) : i_d;

endmodule

// File: rtl/bcd_to_unsigned.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// Optional one-cycle done pulse: define BCD_TO_UNSIGNED_DONE_PULSE_EN.
module bcd_to_unsigned
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int OUT_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          trigger,
    input  logic [BCD_DIGIT_W*N_DIGITS-1:0] in,
    output logic                          idle,
    output logic [OUT_W-1:0]              out,
    output logic                          error
`ifdef BCD_TO_UNSIGNED_DONE_PULSE_EN
    ,
    output logic                          done
`endif
);

    localparam int W     = BCD_DIGIT_W * N_DIGITS;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int EXT_W = (OUT_W > W) ? OUT_W : W;

    generate
        if (OUT_W < bin_width_for(N_DIGITS)) begin : g_width_chk
            $error("bcd_to_unsigned: OUT_W too small for N_DIGITS");
        end
    endgenerate

    state_t             r_state;
    logic [W-1:0]       r_bcd;
    logic [W-1:0]       r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_inv;
    logic               r_idle;
    logic [OUT_W-1:0]   r_out;
    logic               r_err;

    logic [2*W-1:0]     w_shift;
    logic [W-1:0]       w_bcd_shift;
    logic [W-1:0]       w_bcd_next;
    logic [W-1:0]       w_bin_next;
    logic [EXT_W-1:0]   w_bin_ext;
    logic               w_inv;
    logic               w_last;

    assign w_shift     = {r_bcd, r_bin} >> 1;
    assign w_bcd_shift = w_shift[2*W-1:W];
    assign w_bin_next  = w_shift[W-1:0];
    assign w_bin_ext   = EXT_W'(w_bin_next);
    assign w_last      = (r_cnt == CNT_W'(W - 1));

    genvar g;
    generate
        for (g = 0; g < N_DIGITS; g++) begin : g_dig
            bcd_digit_sub3 u_sub3 (
                .i_d (w_bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_d (w_bcd_next[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Any non-decimal nibble poisons the whole conversion.
    always_comb begin
        w_inv = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!digit_valid(in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_inv = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            r_idle  <= 1'b1;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_bcd   <= in;
                        r_bin   <= '0;
                        r_cnt   <= '0;
                        r_inv   <= w_inv;
                        r_idle  <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out   <= r_inv ? '0 : w_bin_ext[OUT_W-1:0];
                        r_err   <= r_inv;
                        r_idle  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign idle  = r_idle;
    assign out   = r_out;
    assign error = r_err;

`ifdef BCD_TO_UNSIGNED_DONE_PULSE_EN
    logic r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == SHIFT) && w_last;
        end
    end

    assign done = r_done;
`endif

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Directed self-checking bench for bcd_to_unsigned.
module tb_bcd_to_unsigned;

    logic        clk;
    logic        reset;
    logic        trigger;
    logic [31:0] in;
    logic        idle;
    logic [31:0] out;
    logic        error;
`ifdef BCD_TO_UNSIGNED_DONE_PULSE_EN
    logic        done;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] prev_out;

    bcd_to_unsigned #(
        .N_DIGITS (8),
        .OUT_W    (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .in      (in),
        .idle    (idle),
        .out     (out),
        .error   (error)
`ifdef BCD_TO_UNSIGNED_DONE_PULSE_EN
        ,
        .done    (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag, input logic exp);
`ifdef BCD_TO_UNSIGNED_DONE_PULSE_EN
        check(tag, {31'd0, done}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("%s", tag);
`endif
    endtask

    // Start a conversion, check latency, hold of old result, final result.
    task automatic convert(input string tag, input logic [31:0] bcd,
                           input logic [31:0] exp_out, input logic exp_err);
        @(negedge clk);
        in      = bcd;
        trigger = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
        check({tag, "_busy"}, {31'd0, idle}, 32'd0);
        check({tag, "_hold"}, out, prev_out);
        repeat (31) @(posedge clk);
        @(negedge clk);
        check({tag, "_lat"}, {31'd0, idle}, 32'd0);
        check_done({tag, "_nodone"}, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle"}, {31'd0, idle}, 32'd1);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_err"}, {31'd0, error}, {31'd0, exp_err});
        check_done({tag, "_done"}, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_done({tag, "_done_end"}, 1'b0);
        prev_out = exp_out;
    endtask

    initial begin
        reset    = 1'b0;
        trigger  = 1'b0;
        in       = '0;
        prev_out = '0;

        #13;
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_out", out, 32'd0);
        check("rst_err", {31'd0, error}, 32'd0);
        check_done("rst_done", 1'b0);
        #1 reset = 1'b1;

        convert("basic42", 32'h0000_0042, 32'd42, 1'b0);
        convert("max", 32'h9999_9999, 32'h05F5_E0FF, 1'b0);
        convert("zero", 32'h0000_0000, 32'd0, 1'b0);
        convert("inv_lo", 32'h0000_001A, 32'd0, 1'b1);
        convert("v235", 32'h0000_0235, 32'd235, 1'b0);
        convert("inv_hi", 32'hF000_0001, 32'd0, 1'b1);
        convert("v7", 32'h0000_0007, 32'd7, 1'b0);

        // Results hold while idle with trigger low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_hold_out", out, 32'd7);
        check("idle_hold_idle", {31'd0, idle}, 32'd1);

        // Back-to-back with trigger held high.
        @(negedge clk);
        in      = 32'h0000_0042;
        trigger = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in = 32'h1000_0235;
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("b2b_lat", {31'd0, idle}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle1", {31'd0, idle}, 32'd1);
        check("b2b_out1", out, 32'd42);
        check_done("b2b_done1", 1'b1);
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
        check("b2b_one_cycle", {31'd0, idle}, 32'd0);
        check("b2b_hold1", out, 32'd42);
        check_done("b2b_done1_end", 1'b0);
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("b2b_lat2", {31'd0, idle}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle2", {31'd0, idle}, 32'd1);
        check("b2b_out2", out, 32'd10000235);
        check("b2b_err2", {31'd0, error}, 32'd0);
        check_done("b2b_done2", 1'b1);

        // Asynchronous reset at cnt=10 aborts the conversion.
        @(negedge clk);
        in      = 32'h0000_5678;
        trigger = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_rst_idle", {31'd0, idle}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_idle", {31'd0, idle}, 32'd1);
        check("mid_rst_out", out, 32'd0);
        check("mid_rst_err", {31'd0, error}, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        prev_out = 32'd0;
        convert("after_rst", 32'h0000_0099, 32'd99, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_unsigned.md
Name: bcd_to_unsigned

Overview:
- Sequential BCD-to-binary converter using reverse double dabble: shift right one bit per clock, then correct each digit.
- Inverse of the existing unsigned_to_bcd converter. Same trigger/idle handshake and same 8-digit packed BCD word, so the pair can be chained (display/keypad path ↔ arithmetic datapath).
- One conversion takes a fixed 4*N_DIGITS shift cycles.

Parameters:
- N_DIGITS, 8, number of packed BCD digits at `in`; input width = 4*N_DIGITS.
- OUT_W, 32, width of `out`.
  - Must satisfy 2^OUT_W > 10^N_DIGITS - 1.
  - Compile-time assertion if violated.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- trigger  input  1  start request, level-sampled while idle.
- in  input  4*N_DIGITS  packed BCD, digit 0 in [3:0].
- idle  output  1  1 = ready / result valid; 0 = converting.
- out  output  OUT_W  binary result, zero-extended.
- error  output  1  last conversion had a nibble > 9.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, idle=1, out=0, error=0.
  - Shift register and counter cleared.
  - Reset asserted mid-conversion aborts it. out is not updated (stays 0).
- States: IDLE, SHIFT.
- IDLE:
  - Each rising edge with trigger=1:
    - capture `in` into bcd_reg[4N-1:0];
    - clear bin_reg[4N-1:0];
    - cnt=0;
    - inv = (any nibble of `in` > 9);
    - idle<=0; go to SHIFT.
  - trigger=0: remain in IDLE; out/error hold.
- SHIFT, each edge:
  - Shift {bcd_reg,bin_reg} right by 1. bcd_reg MSB gets 0.
  - Then, for every digit of the shifted bcd_reg: if digit >= 8, digit -= 3. All digits corrected in parallel, same cycle.
  - cnt++.
- Completion, on the edge where cnt reaches 4*N_DIGITS-1:
  - out <= inv ? 0 : final bin_reg value (truncated/zero-extended to OUT_W);
  - error <= inv;
  - idle<=1; state=IDLE.
- Latency: trigger sampled at edge E0 → idle=1 and out/error valid after edge E0+4*N_DIGITS (32 edges for N=8).
- Conversion inputs and ordering:
  - `in` and trigger are ignored during SHIFT; the captured value is used.
  - trigger held high continuously: idle is high for exactly one cycle between conversions, then the next conversion starts. Throughput = one result per 4*N_DIGITS+1 cycles.
- out and error are stable from completion until the next completion; they are not cleared on trigger.
- Invalid input never produces a partial binary value: out=0 and error=1.

Optional Feature:
- Macro: BCD_TO_UNSIGNED_DONE_PULSE_EN.
- Defined:
  - Extra port `done` (output, 1 bit), reset 0.
  - High for exactly one cycle, on the cycle following the completion edge (coincident with idle rising).
  - Also pulses in the back-to-back case.
- Undefined: port absent; no other behaviour changes.

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT};
  - BCD_DIGIT_W=4;
  - DIGIT_MAX=9;
  - function digit_valid().
  - The package is shared with unsigned_to_bcd for its add-3 constants.
- Sub-module bcd_digit_sub3: combinational 4-bit, out = (d>=8) ? d-3 : d. Instantiated N_DIGITS times with generate.
- Counter width: $clog2(4*N_DIGITS).

Test Plan:
- Basic value: reset low 14 ns, release; in=32'h0000_0042, trigger=1 → after 32 edges idle=1, out=32'd42 (0x2A), error=0.
- Maximum value: in=32'h9999_9999 → out=32'h05F5_E0FF (99999999), error=0. Then in=32'h0000_0000 → out=0.
- Invalid digit: in=32'h0000_001A → out=0, error=1. Next, in=32'h0000_0235 → out=235, error=0.
- Back-to-back, trigger held at 1:
  - in changes from 32'h0000_0042 to 32'h1000_0235 mid-conversion; the first result is still 42.
  - idle is high exactly 1 cycle.
  - The second result is 10000235.
- Reset mid-conversion: reset=0 at cnt=10 → idle=1, out=0, error=0 immediately (asynchronous); after release, conversion of 32'h0000_0099 → 99.
- With BCD_TO_UNSIGNED_DONE_PULSE_EN: done is a single-cycle pulse per completion, including the back-to-back case; it is never high while idle=0.
